// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
//   Run/pause/clear sequencer for the stopwatch. Owns the 13-bit seconds
//   count shown on the display and drives the one-hot scan that
//   time-shares the 4-digit 7-segment panel.
//
//   Optional lap-freeze feature: define STOPWATCH_LAP_EN to enable it.
//   Without the macro, btn_lap is ignored and lap_active stays 0.
//
// Parameters
//   TICK_DIV   clk cycles per counted second (>= 2)
//   SCAN_DIV   clk cycles per panel step (>= 2)
//   MAX_COUNT  saturation value of count (<= 8191)
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   btn_start  1-cycle pulse: start / resume
//   btn_pause  1-cycle pulse: pause
//   btn_clear  1-cycle pulse: clear to 0 (wins over everything)
//   btn_lap    1-cycle pulse: lap freeze toggle
//   count      seconds value to display
//   running    1 while in RUN
//   done       1 while in DONE (saturated)
//   lap_active 1 while the displayed count is frozen
//   panel      one-hot active digit: 0001 min_l, 0010 min_r, 0100 sec_l, 1000 sec_r
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV  = 100_000_000,
  parameter int unsigned SCAN_DIV  = 100_000,
  parameter int unsigned MAX_COUNT = 5999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start,
  input  logic        btn_pause,
  input  logic        btn_clear,
  input  logic        btn_lap,
  output logic [12:0] count,
  output logic        running,
  output logic        done,
  output logic        lap_active,
  output logic [3:0]  panel
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned SW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [12:0]   MAX_C     = 13'(MAX_COUNT);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state, state_n;
  logic [12:0]   sec_cnt, sec_n, count_n;
  logic [PW-1:0] prescaler, pre_n;
  logic          lap_n;
  logic [SW-1:0] scan_cnt;
  logic [1:0]    sel;

  // Start is only honoured when pause is not pulsed in the same cycle.
  logic start_eff;
  assign start_eff = btn_start && !btn_pause;

  always_comb begin
    state_n = state;
    sec_n   = sec_cnt;
    pre_n   = prescaler;
    if (btn_clear) begin
      state_n = IDLE;
      sec_n   = '0;
      pre_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_eff) begin
            state_n = RUN;
            pre_n   = '0;
          end
        end
        RUN: begin
          // Pause wins over a coincident tick: the prescaler keeps its
          // value so the suppressed tick fires on the first RUN cycle.
          if (btn_pause) begin
            state_n = PAUSE;
          end else if (prescaler == PRE_LAST) begin
            pre_n = '0;
            if (sec_cnt < MAX_C) begin
              sec_n = sec_cnt + 13'd1;
              if (sec_n == MAX_C) state_n = DONE;
            end
          end else begin
            pre_n = prescaler + PW'(1);
          end
        end
        PAUSE: begin
          if (start_eff) state_n = RUN;
        end
        default: ;
      endcase
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [12:0] lap_reg, lap_reg_n;

  always_comb begin
    lap_n     = lap_active;
    lap_reg_n = lap_reg;
    if (btn_clear) begin
      lap_n = 1'b0;
    end else if (btn_lap && !btn_pause && !btn_start &&
                 (state == RUN || state == DONE)) begin
      lap_n = !lap_active;
      if (!lap_active) lap_reg_n = sec_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lap_reg <= '0;
    else     lap_reg <= lap_reg_n;
  end

  assign count_n = lap_n ? lap_reg_n : sec_n;
`else
  logic unused_lap;
  assign unused_lap = btn_lap;
  assign lap_n      = 1'b0;
  assign count_n    = sec_n;
`endif

  // Outputs are registered from next-state values so they line up with state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sec_cnt    <= '0;
      prescaler  <= '0;
      count      <= '0;
      running    <= 1'b0;
      done       <= 1'b0;
      lap_active <= 1'b0;
    end else begin
      state      <= state_n;
      sec_cnt    <= sec_n;
      prescaler  <= pre_n;
      count      <= count_n;
      running    <= (state_n == RUN);
      done       <= (state_n == DONE);
      lap_active <= lap_n;
    end
  end

  // Free-running panel scan, independent of the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      sel      <= '0;
      panel    <= 4'b0001;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      sel      <= sel + 2'd1;
      panel    <= 4'b0001 << (sel + 2'd1);
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_start = 1'b0;
  logic        btn_pause = 1'b0;
  logic        btn_clear = 1'b0;
  logic        btn_lap   = 1'b0;
  logic [12:0] count;
  logic        running;
  logic        done;
  logic        lap_active;
  logic [3:0]  panel;

  int tests = 0;
  int fails = 0;
  int edges = 0;

  stopwatch_ctrl #(
    .TICK_DIV (4),
    .SCAN_DIV (2),
    .MAX_COUNT(5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_start (btn_start),
    .btn_pause (btn_pause),
    .btn_clear (btn_clear),
    .btn_lap   (btn_lap),
    .count     (count),
    .running   (running),
    .done      (done),
    .lap_active(lap_active),
    .panel     (panel)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; panel should step every 2 edges.
  always @(posedge clk or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge: drive buttons for exactly one rising edge.
  task automatic press(input logic s, input logic p, input logic c, input logic l);
    btn_start = s; btn_pause = p; btn_clear = c; btn_lap = l;
    @(negedge clk);
    btn_start = 1'b0; btn_pause = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
  endtask

  task automatic check_scan(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag, panel, 4'b0001 << ((edges / 2) % 4));
    end
  endtask

  initial begin
    // reset values
    #2 rst = 1'b1;
    #1;
    check("rst_count", count, 0);
    check("rst_running", running, 0);
    check("rst_done", done, 0);
    check("rst_lap", lap_active, 0);
    check("rst_panel", panel, 4'b0001);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // panel scan in IDLE
    check_scan("scan_idle", 10);

    // run, pause, resume
    press(1, 0, 0, 0);
    tick_n(12);
    check("run12_count", count, 3);
    check("run12_running", running, 1);
    press(0, 1, 0, 0);
    check("pause_running", running, 0);
    tick_n(20);
    check("pause_hold", count, 3);
    press(1, 0, 0, 0);
    check("resume_running", running, 1);
    tick_n(3);
    check("resume_pre3", count, 3);
    tick_n(1);
    check("resume_tick", count, 4);

    // pause coincident with tick, resume ticks on first RUN cycle -> saturate
    tick_n(3);
    press(0, 1, 0, 0);
    check("pause_on_tick", count, 4);
    press(1, 0, 0, 0);
    check("resume_edge", count, 4);
    tick_n(1);
    check("sat_count", count, 5);
    check("sat_done", done, 1);
    check("sat_running", running, 0);

    // DONE ignores start/pause
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    tick_n(20);
    press(1, 0, 0, 0);
    check("done_hold_count", count, 5);
    check("done_hold_done", done, 1);
    check("done_hold_running", running, 0);
    check_scan("scan_done", 10);
    press(0, 0, 1, 0);
    check("clr_count", count, 0);
    check("clr_done", done, 0);
    check("clr_running", running, 0);

    // pause ignored in IDLE; pause+clear in RUN
    press(0, 1, 0, 0);
    check("idle_pause", running, 0);
    press(1, 0, 0, 0);
    tick_n(4);
    check("run4_count", count, 1);
    press(0, 1, 1, 0);
    check("pclr_count", count, 0);
    check("pclr_running", running, 0);
    tick_n(8);
    check("pclr_idle", count, 0);

    // start+pause in PAUSE stays paused
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    press(1, 1, 0, 0);
    check("sp_running", running, 0);
    tick_n(8);
    check("sp_count", count, 0);
    press(1, 0, 0, 0);
    check("sp_resume", running, 1);
    tick_n(3);
    check("sp_pre3", count, 0);
    tick_n(1);
    check("sp_tick", count, 1);

    // lap
    press(0, 0, 1, 0);
    press(1, 0, 0, 0);
    tick_n(8);
    check("lap_pre", count, 2);
    press(0, 0, 0, 1);
    tick_n(8);
`ifdef STOPWATCH_LAP_EN
    check("lap_frozen", count, 2);
    check("lap_active_set", lap_active, 1);
`else
    check("lap_ign_count", count, 4);
    check("lap_ign_active", lap_active, 0);
`endif
    press(0, 0, 0, 1);
    check("lap_release", count, 4);
    check("lap_active_clr", lap_active, 0);
    press(0, 0, 0, 1);
    tick_n(2);
    check("lap_sat_done", done, 1);
`ifdef STOPWATCH_LAP_EN
    check("lap_sat_frozen", count, 4);
    check("lap_sat_active", lap_active, 1);
`else
    check("lap_sat_count", count, 5);
    check("lap_sat_active", lap_active, 0);
`endif
    press(0, 0, 0, 1);
    check("lap_done_rel", count, 5);
    check("lap_done_act", lap_active, 0);
    press(0, 0, 0, 1);
`ifdef STOPWATCH_LAP_EN
    check("lap_done_set", lap_active, 1);
`else
    check("lap_done_set", lap_active, 0);
`endif
    press(0, 0, 1, 0);
    check("lap_clr_active", lap_active, 0);
    check("lap_clr_count", count, 0);

    // asynchronous reset mid-RUN
    press(1, 0, 0, 0);
    tick_n(12);
    check("arst_pre_count", count, 3);
    #2 rst = 1'b1;
    #1;
    check("arst_count", count, 0);
    check("arst_running", running, 0);
    check("arst_done", done, 0);
    check("arst_panel", panel, 4'b0001);
    @(negedge clk);
    rst = 1'b0;
    tick_n(6);
    check("arst_idle_count", count, 0);
    check("arst_idle_running", running, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
